eh2_bp_ghr_fold: RTL and testbench

Per-thread global-history manager for the branch predictor. Keeps an architectural and a speculative GHR per thread, an incrementally maintained XOR-folded copy of the speculative GHR, and a per-thread in-flight prediction counter with backpressure. It supplies the BHT index (`pc hash ^ folded history`) to the predictor front end and repairs history on mispredict or flush. Generalises the fixed-width GHR hashing to arbitrary history length, fold width and thread count.

---
 rtl/eh2_bp_ghr_fold.sv | 121 ++++++++++++
 tb/tb_eh2_bp_ghr_fold.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_bp_ghr_fold.sv
`default_nettype none
// ============================================================================
// Module   : eh2_bp_ghr_fold
// Brief    : Per-thread global-history manager. Holds architectural and
//            speculative GHRs, an incrementally folded copy of the
//            speculative GHR used to form the BHT index, and an in-flight
//            prediction counter that provides backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module eh2_bp_ghr_fold #(
    parameter int NUM_THREADS = 2,
    parameter int GHR_SIZE    = 9,
    parameter int FOLD_W      = 7,
    parameter int INFL_DEPTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_THREADS-1:0]                 pred_valid,
    input  logic [NUM_THREADS-1:0]                 pred_taken,
    output logic [NUM_THREADS-1:0]                 pred_ready,
    input  logic [NUM_THREADS-1:0]                 cmt_valid,
    input  logic [NUM_THREADS-1:0]                 cmt_taken,
    input  logic [NUM_THREADS-1:0]                 cmt_mp,
    input  logic [NUM_THREADS-1:0]                 flush,
    input  logic [NUM_THREADS-1:0][FOLD_W-1:0]     pc_hash,
    output logic [NUM_THREADS-1:0][FOLD_W-1:0]     bht_index,
    output logic [NUM_THREADS-1:0][GHR_SIZE-1:0]   ghr_spec,
    output logic [NUM_THREADS-1:0][GHR_SIZE-1:0]   ghr_arch,
    output logic [NUM_THREADS-1:0][3:0]            infl_cnt
);

    // Fold position where the bit falling off the top of the GHR used to sit
    // after one rotation of the folded value.
    localparam int                c_EVICT_POS    = GHR_SIZE % FOLD_W;
    localparam logic [FOLD_W-1:0] c_EVICT_ONEHOT = (FOLD_W)'(1) << c_EVICT_POS;
    localparam logic [3:0]        c_DEPTH        = 4'(INFL_DEPTH);

    // Full XOR fold: bit j of the history lands on fold bit (j mod FOLD_W).
    function automatic logic [FOLD_W-1:0] fold_full(input logic [GHR_SIZE-1:0] h);
        logic [FOLD_W-1:0] f;
        f = '0;
        for (int j = 0; j < GHR_SIZE; j++) begin
            f[j % FOLD_W] = f[j % FOLD_W] ^ h[j];
        end
        return f;
    endfunction

    // Rotate left by one; written as a loop so FOLD_W == 1 needs no special case.
    function automatic logic [FOLD_W-1:0] rotl1(input logic [FOLD_W-1:0] f);
        logic [FOLD_W-1:0] r;
        r = '0;
        for (int i = 0; i < FOLD_W; i++) begin
            r[(i + 1) % FOLD_W] = f[i];
        end
        return r;
    endfunction

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        logic [GHR_SIZE-1:0] r_spec;
        logic [GHR_SIZE-1:0] r_arch;
        logic [FOLD_W-1:0]   r_fold;
        logic [3:0]          r_cnt;

        logic                w_ready;
        logic                w_repair;
        logic                w_accept;
        logic [GHR_SIZE-1:0] w_arch_nxt;
        logic [FOLD_W-1:0]   w_fold_inc;

        assign w_ready    = (r_cnt < c_DEPTH);
        // Mispredict and flush both rebuild speculation from the committed history.
        assign w_repair   = flush[t] | (cmt_valid[t] & cmt_mp[t]);
        assign w_accept   = pred_valid[t] & w_ready & ~w_repair;
        assign w_arch_nxt = cmt_valid[t] ? {r_arch[GHR_SIZE-2:0], cmt_taken[t]} : r_arch;
        // Shifting the GHR rotates every fold contribution by one; the new bit
        // enters at 0 and the evicted oldest bit is cancelled at its rotated slot.
        assign w_fold_inc = rotl1(r_fold)
                          ^ (FOLD_W)'(pred_taken[t])
                          ^ (r_spec[GHR_SIZE-1] ? c_EVICT_ONEHOT : '0);

        // History, fold and in-flight counter state for this thread.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_spec <= '0;
                r_arch <= '0;
                r_fold <= '0;
                r_cnt  <= '0;
            end else begin
                r_arch <= w_arch_nxt;
                if (w_repair) begin
                    r_spec <= w_arch_nxt;
                    r_fold <= fold_full(w_arch_nxt);
                    r_cnt  <= '0;
                end else begin
                    if (w_accept) begin
                        r_spec <= {r_spec[GHR_SIZE-2:0], pred_taken[t]};
                        r_fold <= w_fold_inc;
                    end
                    // A commit with nothing in flight leaves the count pinned at zero.
                    if (w_accept && !cmt_valid[t]) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (!w_accept && cmt_valid[t] && (r_cnt != 4'd0)) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            end
        end

        // A commit must always have a matching in-flight prediction.
        a_cmt_underflow : assert property (@(posedge clk) disable iff (rst)
            !(cmt_valid[t] && (r_cnt == 4'd0)));

        assign pred_ready[t] = w_ready;
        assign bht_index[t]  = pc_hash[t] ^ r_fold;
        assign ghr_spec[t]   = r_spec;
        assign ghr_arch[t]   = r_arch;
        assign infl_cnt[t]   = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_eh2_bp_ghr_fold.sv
`default_nettype none
// ============================================================================
// Module   : tb_eh2_bp_ghr_fold
// Brief    : Self-checking bench for eh2_bp_ghr_fold (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eh2_bp_ghr_fold;

    logic             clk;
    logic             rst;
    logic [1:0]       pred_valid, pred_taken, pred_ready;
    logic [1:0]       cmt_valid, cmt_taken, cmt_mp, flush;
    logic [1:0][6:0]  pc_hash, bht_index;
    logic [1:0][8:0]  ghr_spec, ghr_arch;
    logic [1:0][3:0]  infl_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    eh2_bp_ghr_fold #(
        .NUM_THREADS(2), .GHR_SIZE(9), .FOLD_W(7), .INFL_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .cmt_valid(cmt_valid), .cmt_taken(cmt_taken), .cmt_mp(cmt_mp),
        .flush(flush), .pc_hash(pc_hash), .bht_index(bht_index),
        .ghr_spec(ghr_spec), .ghr_arch(ghr_arch), .infl_cnt(infl_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       pv, pt, cv, ct, mp, fl;
        logic [8:0] e_spec;
        logic [8:0] e_arch;
        logic [3:0] e_cnt;
        logic       e_rdy;
        logic [6:0] e_fold;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t v(bit pv, bit pt, bit cv, bit ct, bit mp, bit fl,
                               int s, int a, int c, bit r, int f);
        vec_t x;
        x.pv = pv; x.pt = pt; x.cv = cv; x.ct = ct; x.mp = mp; x.fl = fl;
        x.e_spec = 9'(s); x.e_arch = 9'(a); x.e_cnt = 4'(c);
        x.e_rdy = r; x.e_fold = 7'(f);
        return x;
    endfunction

    // Fold straight from the definition.
    function automatic logic [6:0] fold_of(logic [8:0] h);
        logic [6:0] f;
        f = '0;
        for (int j = 0; j < 9; j++) f[j % 7] = f[j % 7] ^ h[j];
        return f;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        pred_valid = '0; pred_taken = '0; cmt_valid = '0;
        cmt_taken = '0; cmt_mp = '0; flush = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    // Behavioural reference state for the random phase.
    logic [8:0] m_spec [2];
    logic [8:0] m_arch [2];
    int         m_cnt  [2];

    initial begin
        rst = 1'b1;
        idle();
        pc_hash[0] = 7'h55;
        pc_hash[1] = 7'h2A;
        #1;
        // Reset state (reset held).
        chk("rst_spec0", int'(ghr_spec[0]), 0);
        chk("rst_arch1", int'(ghr_arch[1]), 0);
        chk("rst_cnt0",  int'(infl_cnt[0]), 0);
        chk("rst_ready", int'(pred_ready), 3);
        chk("rst_bht0",  int'(bht_index[0]), 'h55);
        chk("rst_bht1",  int'(bht_index[1]), 'h2A);
        #12;
        rst = 1'b0;
        pc_hash = '0;

        // ---------------- table-driven thread-0 sequence ----------------
        vecs[0]  = v(1,1,0,0,0,0, 'h001,'h000,1,1,'h01);
        vecs[1]  = v(1,1,0,0,0,0, 'h003,'h000,2,1,'h03);
        vecs[2]  = v(1,0,0,0,0,0, 'h006,'h000,3,1,'h06);
        vecs[3]  = v(1,1,0,0,0,0, 'h00D,'h000,4,0,'h0D);
        vecs[4]  = v(1,0,0,0,0,0, 'h00D,'h000,4,0,'h0D);
        vecs[5]  = v(0,0,1,1,0,0, 'h00D,'h001,3,1,'h0D);
        vecs[6]  = v(1,1,1,0,0,0, 'h01B,'h002,3,1,'h1B);
        vecs[7]  = v(1,1,1,1,1,0, 'h005,'h005,0,1,'h05);
        vecs[8]  = v(1,0,0,0,0,0, 'h00A,'h005,1,1,'h0A);
        vecs[9]  = v(1,0,0,0,0,0, 'h014,'h005,2,1,'h14);
        vecs[10] = v(1,1,0,0,0,0, 'h029,'h005,3,1,'h29);
        vecs[11] = v(1,1,1,1,1,0, 'h00B,'h00B,0,1,'h0B);
        vecs[12] = v(1,1,0,0,0,0, 'h017,'h00B,1,1,'h17);
        vecs[13] = v(1,1,0,0,0,0, 'h02F,'h00B,2,1,'h2F);
        vecs[14] = v(0,0,1,0,0,0, 'h02F,'h016,1,1,'h2F);
        vecs[15] = v(1,1,1,0,0,1, 'h02C,'h02C,0,1,'h2C);
        vecs[16] = v(1,1,0,0,0,0, 'h059,'h02C,1,1,'h59);
        vecs[17] = v(0,0,0,0,0,1, 'h02C,'h02C,0,1,'h2C);
        for (int i = 0; i < 18; i++) begin
            idle();
            pred_valid[0] = vecs[i].pv; pred_taken[0] = vecs[i].pt;
            cmt_valid[0]  = vecs[i].cv; cmt_taken[0]  = vecs[i].ct;
            cmt_mp[0]     = vecs[i].mp; flush[0]      = vecs[i].fl;
            step();
            chk($sformatf("tbl%0d_spec", i), int'(ghr_spec[0]), int'(vecs[i].e_spec));
            chk($sformatf("tbl%0d_arch", i), int'(ghr_arch[0]), int'(vecs[i].e_arch));
            chk($sformatf("tbl%0d_cnt", i),  int'(infl_cnt[0]), int'(vecs[i].e_cnt));
            chk($sformatf("tbl%0d_rdy", i),  int'(pred_ready[0]), int'(vecs[i].e_rdy));
            chk($sformatf("tbl%0d_fold", i), int'(bht_index[0]), int'(vecs[i].e_fold));
            chk($sformatf("tbl%0d_t1", i),   int'({ghr_spec[1], ghr_arch[1], infl_cnt[1]}), 0);
        end
        idle();

        // ---------------- flush + plain commit, thread 1 busy ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            pred_valid = 2'b11; pred_taken = 2'b11;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            cmt_valid[0] = 1'b1; cmt_taken[0] = 1'b1;
            step();
        end
        chk("fc_arch_pre", int'(ghr_arch[0]), 'h003);
        idle();
        flush[0] = 1'b1; cmt_valid[0] = 1'b1; cmt_taken[0] = 1'b0;
        step();
        idle();
        chk("fc_arch", int'(ghr_arch[0]), 'h006);
        chk("fc_spec", int'(ghr_spec[0]), 'h006);
        chk("fc_cnt",  int'(infl_cnt[0]), 0);
        chk("fc_fold", int'(bht_index[0]), 'h06);
        chk("fc_t1_spec", int'(ghr_spec[1]), 'h007);
        chk("fc_t1_cnt",  int'(infl_cnt[1]), 3);

        // ---------------- eviction wrap ----------------
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            idle();
            pred_valid[0] = 1'b1; pred_taken[0] = 1'b1;
            if (i > 1) begin
                cmt_valid[0] = 1'b1; cmt_taken[0] = 1'b1;
            end
            step();
            if (i >= 9) begin
                chk($sformatf("wrap%0d_spec", i), int'(ghr_spec[0]), 'h1FF);
                chk($sformatf("wrap%0d_fold", i), int'(bht_index[0]), 'h7C);
                chk($sformatf("wrap%0d_cnt", i),  int'(infl_cnt[0]), 1);
            end
        end
        idle();
        chk("wrap_arch", int'(ghr_arch[0]), 'h1FF);
        pc_hash[0] = 7'h7F;
        #1;
        chk("wrap_bht", int'(bht_index[0]), 'h03);

        // ---------------- asynchronous reset between edges ----------------
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_spec",  int'(ghr_spec), 0);
        chk("arst_arch",  int'(ghr_arch), 0);
        chk("arst_cnt",   int'(infl_cnt), 0);
        chk("arst_ready", int'(pred_ready), 3);
        chk("arst_bht",   int'(bht_index[0]), 'h7F);
        #2;
        rst = 1'b0;
        pc_hash = '0;
        for (int t = 0; t < 2; t++) begin
            m_spec[t] = '0; m_arch[t] = '0; m_cnt[t] = 0;
        end

        // ---------------- random stress against the model ----------------
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [8:0] an, sn;
            bit         acc;
            idle();
            for (int t = 0; t < 2; t++) begin
                pred_valid[t] = ($urandom_range(0, 3) != 0);
                pred_taken[t] = $urandom_range(0, 1) == 1;
                cmt_valid[t]  = (m_cnt[t] > 0) && ($urandom_range(0, 2) == 0);
                cmt_taken[t]  = $urandom_range(0, 1) == 1;
                cmt_mp[t]     = ($urandom_range(0, 9) == 0);
                flush[t]      = ($urandom_range(0, 29) == 0);
                pc_hash[t]    = 7'($urandom);
            end
            step();
            for (int t = 0; t < 2; t++) begin
                acc = pred_valid[t] && (m_cnt[t] < 4) && !flush[t] && !(cmt_valid[t] && cmt_mp[t]);
                an  = cmt_valid[t] ? {m_arch[t][7:0], cmt_taken[t]} : m_arch[t];
                if ((cmt_valid[t] && cmt_mp[t]) || flush[t]) begin
                    sn = an;
                    m_cnt[t] = 0;
                end else begin
                    sn = acc ? {m_spec[t][7:0], pred_taken[t]} : m_spec[t];
                    m_cnt[t] = m_cnt[t] + (acc ? 1 : 0) - (cmt_valid[t] ? 1 : 0);
                end
                m_arch[t] = an;
                m_spec[t] = sn;
                chk($sformatf("rnd%0d_t%0d_spec", cyc, t), int'(ghr_spec[t]), int'(m_spec[t]));
                chk($sformatf("rnd%0d_t%0d_arch", cyc, t), int'(ghr_arch[t]), int'(m_arch[t]));
                chk($sformatf("rnd%0d_t%0d_cnt", cyc, t),  int'(infl_cnt[t]), m_cnt[t]);
                chk($sformatf("rnd%0d_t%0d_rdy", cyc, t),  int'(pred_ready[t]), (m_cnt[t] < 4) ? 1 : 0);
                chk($sformatf("rnd%0d_t%0d_bht", cyc, t),  int'(bht_index[t]),
                    int'(pc_hash[t] ^ fold_of(m_spec[t])));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
